lsu_ctrl: RTL and testbench

- Load/store unit sitting directly upstream of the unified byte-addressed memory's data port.
- Accepts one load/store request at a time from the execute stage and validates alignment and address range.
- Translates RISC-V funct3 into the memory's dm_rd_ctrl/dm_wr_ctrl codes, drives the data port, and returns load data or an error through a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 73 +++++++
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_load_ext.sv | 21 ++
 rtl/lsu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 values, memory port codes,
// FSM states and access sizes, plus small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_B    = 2'b01;
    localparam logic [1:0] WR_H    = 2'b10;
    localparam logic [1:0] WR_W    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    // Encoded as the byte count so it can feed the range adder directly.
    typedef enum logic [2:0] {
        SZ_B = 3'd1,
        SZ_H = 3'd2,
        SZ_W = 3'd4
    } lsu_size_e;

    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic [2:0] rd_code(input logic [2:0] f3);
        case (f3)
            F3_LB:   return RD_LB;
            F3_LH:   return RD_LH;
            F3_LW:   return RD_LW;
            F3_LBU:  return RD_LBU;
            F3_LHU:  return RD_LHU;
            default: return RD_NONE;
        endcase
    endfunction

    function automatic logic [1:0] wr_code(input logic [2:0] f3);
        case (f3)
            F3_SB:   return WR_B;
            F3_SH:   return WR_H;
            F3_SW:   return WR_W;
            default: return WR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response channel and memory data port of the load/store unit.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [2:0]        dm_rd_ctrl;
    logic [1:0]        dm_wr_ctrl;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dm_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               dm_rd_ctrl, dm_wr_ctrl, dm_addr, dm_din
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dm_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               dm_rd_ctrl, dm_wr_ctrl, dm_addr, dm_din
    );
endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of right-aligned load data to 32 bits.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    logic sext;

    always_comb begin
        sext   = !unsigned_i;
        data_o = raw_i;
        case (size_i)
            SZ_B:    data_o = {{24{sext & raw_i[7]}}, raw_i[7:0]};
            SZ_H:    data_o = {{16{sext & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: validates one request at a time, drives the memory port for
// one ACCESS cycle and returns data/error. LSU_MISALIGN_SPLIT_EN splits misaligned accesses into byte beats.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 16384,
    parameter int ADDR_W    = 32
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);
    lsu_state_e        state_q;
    logic              ready_q, rsp_valid_q, rsp_err_q, we_q;
    logic [31:0]       rsp_rdata_q, dm_din_q;
    logic [2:0]        f3_q, rd_ctrl_q;
    logic [1:0]        wr_ctrl_q;
    logic [ADDR_W-1:0] dm_addr_q;

    lsu_size_e         req_size, acc_size;
    logic              req_misal, req_oor, req_err;
    logic [ADDR_W:0]   req_last;
    logic [2:0]        rd_ctrl_d;
    logic [1:0]        wr_ctrl_d;
    logic [31:0]       dm_din_d, ext_raw, ext_data;

    assign req_size  = f3_size(bus.req_funct3);
    assign req_misal = ((req_size == SZ_H) && bus.req_addr[0]) ||
                       ((req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
    // One extra bit so an access wrapping past the top of the address space still faults.
    assign req_last  = {1'b0, bus.req_addr} + {{(ADDR_W-2){1'b0}}, req_size} - (ADDR_W+1)'(1);
    assign req_oor   = (req_last >= (ADDR_W+1)'(MEM_BYTES));

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_q;
    logic [1:0]  beat_q, last_beat;
    logic [31:0] asm_q, wdata_q, wdata_sh;

    assign req_err   = !f3_legal(bus.req_we, bus.req_funct3) || req_oor;
    assign last_beat = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    assign wdata_sh  = wdata_q >> {beat_q + 2'd1, 3'b000};
    assign ext_raw   = split_q ? (asm_q | ({24'h0, bus.dm_dout[7:0]} << {beat_q, 3'b000}))
                               : bus.dm_dout;
`else
    assign req_err   = !f3_legal(bus.req_we, bus.req_funct3) || req_oor || req_misal;
    assign ext_raw   = bus.dm_dout;
`endif

    always_comb begin
        rd_ctrl_d = bus.req_we ? RD_NONE : rd_code(bus.req_funct3);
        wr_ctrl_d = bus.req_we ? wr_code(bus.req_funct3) : WR_NONE;
        dm_din_d  = bus.req_we ? bus.req_wdata : 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        // First byte beat of a split access.
        if (req_misal) begin
            rd_ctrl_d = bus.req_we ? RD_NONE : RD_LBU;
            wr_ctrl_d = bus.req_we ? WR_B : WR_NONE;
            dm_din_d  = {24'h0, dm_din_d[7:0]};
        end
`endif
    end

    assign acc_size = f3_size(f3_q);

    lsu_load_ext u_ext (
        .raw_i      (ext_raw),
        .size_i     (acc_size),
        .unsigned_i (f3_q[2]),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rd_ctrl_q   <= RD_NONE;
            wr_ctrl_q   <= WR_NONE;
            dm_addr_q   <= '0;
            dm_din_q    <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            beat_q      <= '0;
            asm_q       <= '0;
            wdata_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ready_q <= 1'b0;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_q <= req_misal;
                        beat_q  <= '0;
                        asm_q   <= '0;
                        wdata_q <= bus.req_wdata;
`endif
                        if (req_err) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q   <= ST_ACCESS;
                            rd_ctrl_q <= rd_ctrl_d;
                            wr_ctrl_q <= wr_ctrl_d;
                            dm_addr_q <= bus.req_addr;
                            dm_din_q  <= dm_din_d;
                        end
                    end
                end
                ST_ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q && (beat_q != last_beat)) begin
                        beat_q    <= beat_q + 2'd1;
                        asm_q     <= ext_raw;
                        dm_addr_q <= dm_addr_q + ADDR_W'(1);
                        dm_din_q  <= we_q ? {24'h0, wdata_sh[7:0]} : 32'h0;
                    end else begin
`endif
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : ext_data;
                        rd_ctrl_q   <= RD_NONE;
                        wr_ctrl_q   <= WR_NONE;
                        dm_addr_q   <= '0;
                        dm_din_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.dm_rd_ctrl = rd_ctrl_q;
    assign bus.dm_wr_ctrl = wr_ctrl_q;
    assign bus.dm_addr    = dm_addr_q;
    assign bus.dm_din     = dm_din_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; the LSU_MISALIGN_SPLIT_EN build swaps the misaligned-LH case for a split check.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] dout_v;
    logic        mem_mode;
    assign bus.dm_dout = mem_mode ? {24'h0, bus.dm_addr[7:0] + 8'h7D} : dout_v;

    int n_chk = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    // Counts memory-port cycles that actually reach a closing edge.
    always @(posedge clk) begin
        if (bus.dm_rd_ctrl != 3'b000) rd_cnt <= rd_cnt + 1;
        if (bus.dm_wr_ctrl != 2'b00)  wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] dout, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic [2:0] exp_rd,
                           input logic [1:0] exp_wr, input logic [31:0] exp_din);
        int rd0, wr0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        drive_req(we, f3, addr, wdata);
        dout_v = dout;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        if (!exp_err) begin
            chk({tag, ".acc_rd"},   32'(bus.dm_rd_ctrl), 32'(exp_rd));
            chk({tag, ".acc_wr"},   32'(bus.dm_wr_ctrl), 32'(exp_wr));
            chk({tag, ".acc_addr"}, bus.dm_addr, addr);
            if (we) chk({tag, ".acc_din"}, bus.dm_din, exp_din);
            chk({tag, ".acc_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, ".rsp_err"},   32'(bus.rsp_err), 32'(exp_err));
        chk({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, ".resp_rd"},   32'(bus.dm_rd_ctrl), 32'd0);
        chk({tag, ".resp_wr"},   32'(bus.dm_wr_ctrl), 32'd0);
        @(negedge clk);
        chk({tag, ".idle_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, ".rd_cycles"},  32'(rd_cnt - rd0), (exp_rd != 3'b000) ? 32'd1 : 32'd0);
        chk({tag, ".wr_cycles"},  32'(wr_cnt - wr0), (exp_wr != 2'b00) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int rd0, wr0;
        int waited;
        logic [31:0] held;

        rst_n = 1'b0;
        mem_mode = 1'b0;
        dout_v = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        #12;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("rst.dm_rd",     32'(bus.dm_rd_ctrl), 32'd0);
        chk("rst.dm_wr",     32'(bus.dm_wr_ctrl), 32'd0);
        chk("rst.dm_addr",   bus.dm_addr, 32'h0);
        chk("rst.dm_din",    bus.dm_din, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("lw",      1'b0, F3_LW,  32'h0000_0100, 32'h0, 32'h8000_1234, 1'b0, 32'h8000_1234, RD_LW,  WR_NONE, 32'h0);
        run_req("lb",      1'b0, F3_LB,  32'h0000_0101, 32'h0, 32'h0000_00F0, 1'b0, 32'hFFFF_FFF0, RD_LB,  WR_NONE, 32'h0);
        run_req("lbu",     1'b0, F3_LBU, 32'h0000_0101, 32'h0, 32'h0000_00F0, 1'b0, 32'h0000_00F0, RD_LBU, WR_NONE, 32'h0);
        run_req("lh",      1'b0, F3_LH,  32'h0000_0102, 32'h0, 32'h0000_8001, 1'b0, 32'hFFFF_8001, RD_LH,  WR_NONE, 32'h0);
        run_req("lhu",     1'b0, F3_LHU, 32'h0000_0102, 32'h0, 32'h0000_8001, 1'b0, 32'h0000_8001, RD_LHU, WR_NONE, 32'h0);
        run_req("sw_top",  1'b1, F3_SW,  32'h0000_3FFC, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0, RD_NONE, WR_W, 32'hDEAD_BEEF);
        run_req("sb_last", 1'b1, F3_SB,  32'h0000_3FFF, 32'h1234_5678, 32'h0, 1'b0, 32'h0, RD_NONE, WR_B, 32'h1234_5678);
        run_req("sw_oor",  1'b1, F3_SW,  32'h0000_3FFE, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
        run_req("sh_oor",  1'b1, F3_SH,  32'h0000_3FFF, 32'h0000_ABCD, 32'h0, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
        run_req("lw_oor",  1'b0, F3_LW,  32'h0000_4000, 32'h0, 32'h5555_5555, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
        run_req("lw_wrap", 1'b0, F3_LW,  32'hFFFF_FFFC, 32'h0, 32'h5555_5555, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
        run_req("ld_f3_3", 1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'h5555_5555, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
        run_req("st_f3_4", 1'b1, 3'b100, 32'h0000_0200, 32'h1, 32'h0, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Bytes at 0x203/0x204 read back as 0x80/0x81 from the address-derived model.
        mem_mode = 1'b1;
        @(negedge clk);
        rd0 = rd_cnt;
        drive_req(1'b0, F3_LH, 32'h0000_0203, 32'h0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!bus.rsp_valid && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 10) chk("split.timeout", 32'd0, 32'd1);
        chk("split.beats", 32'(waited), 32'd2);
        chk("split.rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("split.rsp_rdata", bus.rsp_rdata, 32'hFFFF_8180);
        chk("split.rd_cycles", 32'(rd_cnt - rd0), 32'd2);
        @(negedge clk);
        mem_mode = 1'b0;
`else
        run_req("lh_mis", 1'b0, F3_LH, 32'h0000_0203, 32'h0, 32'h0000_8180, 1'b1, 32'h0, RD_NONE, WR_NONE, 32'h0);
`endif

        // Back-pressure: response held, second request ignored until the handshake.
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        drive_req(1'b0, F3_LW, 32'h0000_0010, 32'h0);
        dout_v = 32'h1122_3344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp.rsp_rdata", bus.rsp_rdata, 32'h1122_3344);
        held = bus.rsp_rdata;
        rd0 = rd_cnt;
        drive_req(1'b0, F3_LW, 32'h0000_0020, 32'h0);
        dout_v = 32'h9999_9999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp.hold_rdata", bus.rsp_rdata, held);
            chk("bp.hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp.after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp.after_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("bp.ignored_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("bp.still_idle", 32'(bus.rsp_valid), 32'd0);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        drive_req(1'b1, F3_SW, 32'h0000_0040, 32'hCAFE_F00D);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid.acc_wr", 32'(bus.dm_wr_ctrl), 32'(WR_W));
        wr0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.wr",        32'(bus.dm_wr_ctrl), 32'd0);
        chk("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_mid.dm_addr",   bus.dm_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.no_write",  32'(wr_cnt - wr0), 32'd0);
        chk("rst_mid.req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid.no_rsp",    32'(bus.rsp_valid), 32'd0);

        run_req("post_rst", 1'b0, F3_LBU, 32'h0000_0041, 32'h0, 32'h0000_007F, 1'b0, 32'h0000_007F, RD_LBU, WR_NONE, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
